paddle_ctrl: RTL and testbench
==============================

Name: paddle_ctrl

Overview:
- Input-conditioning and paddle-motion stage directly upstream of the pong renderer/game core.
- Takes raw btnU/btnD, synchronizes and debounces them, and steps a clamped paddle vertical position once per video frame.
- The renderer consumes paddle_y to draw the paddle.

Parameters:
- DEB_CYCLES, 500000: stable-input cycles needed to accept a button change (10 ms at 50 MHz).
- SCREEN_H, 480: visible lines.
- PADDLE_H, 80: paddle height in lines.
- STEP, 4: lines moved per frame.
- Y_INIT, 200: reset paddle top position.
- Y_W, 10: width of paddle_y.

Ports:
- ClkPort  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- btnU  in  1  raw up button, asynchronous to ClkPort.
- btnD  in  1  raw down button, asynchronous to ClkPort.
- frame_tick  in  1  one-cycle pulse at start of vertical blank, from the VGA timing stage.
- paddle_y  out  Y_W  paddle top line, range 0..SCREEN_H-PADDLE_H.
- up_db  out  1  debounced up level.
- down_db  out  1  debounced down level.
- moving  out  1  high for one cycle after a frame_tick that changed paddle_y.

Behaviour:
- Reset values: paddle_y=Y_INIT, up_db=0, down_db=0, moving=0, synchronizers=0, counters=0, FSM=HOLD.
- Reset is asynchronous, so assertion mid-debounce or mid-step aborts immediately. No partial update survives.
- Synchronizer: 2-FF per button. Metastability latency is 2 cycles.
- Debounce, per button: counter cnt of width clog2(DEB_CYCLES).
  - If sync level equals db: cnt clears to 0.
  - Otherwise cnt increments. When cnt==DEB_CYCLES-1 and the level still differs, db takes sync level and cnt clears.
  - Any glitch back to db before that point clears cnt.
  - Total latency from raw edge to db change is DEB_CYCLES+2 cycles.
- Direction FSM states: HOLD, UP, DOWN. Next state is evaluated every cycle from the debounced levels:
  - up_db & ~down_db -> UP
  - down_db & ~up_db -> DOWN
  - both set or both clear -> HOLD
- Position update happens only in the cycle where frame_tick=1, using the FSM state registered before that edge. paddle_y is visible one cycle after frame_tick.
  - UP: paddle_y <= (paddle_y >= STEP) ? paddle_y-STEP : 0.
  - DOWN: with MAX = SCREEN_H-PADDLE_H, paddle_y <= (paddle_y+STEP <= MAX) ? paddle_y+STEP : MAX. The sum is computed at Y_W+1 bits, so there is no wrap.
  - HOLD: no change.
- moving: asserted the cycle after frame_tick only if the new paddle_y differs from the old one. It stays 0 when clamped at 0 or MAX.
- Button changes between ticks take effect only at the next tick. frame_tick asserted on consecutive cycles gives one step per cycle; no pulse is ever dropped.

Optional Feature:
- Macro: PADDLE_ACCEL_EN.
- Defined:
  - A 3-bit hold counter counts consecutive frame_ticks in the same non-HOLD state.
  - Effective step is STEP for ticks 1–8, 2*STEP for ticks 9–16, then 4*STEP (saturating).
  - Entering HOLD or reversing direction resets the counter and step to STEP.
  - Clamping rules are unchanged.
- Undefined: fixed STEP, and no accel logic is synthesized.

Decomposition:
- pong_pkg holds SCREEN_H, Y_W and the direction typedef (HOLD/UP/DOWN, 2 bits). The renderer and ball logic share these.
- Sub-module btn_debounce (synchronizer + counter, parameter DEB_CYCLES) is instantiated twice, for up and down.

Test Plan:
All cases use DEB_CYCLES=4.
- Reset: assert reset mid-run with paddle_y=120 -> paddle_y=200, up_db=down_db=0, moving=0 immediately, without waiting for a clock edge.
- Debounce glitch: btnU high for 3 cycles then low -> up_db stays 0. btnU high for 10 cycles -> up_db rises exactly 6 cycles after the raw edge.
- Step up: up_db=1, paddle_y=200, 5 frame_ticks -> paddle_y=180, with moving pulsed once per tick.
- Clamp: paddle_y=2 with UP tick -> 0, moving=1. Next tick -> 0, moving=0. paddle_y=398 with DOWN tick -> 400 (MAX); further ticks stay at 400 with moving=0.
- Both buttons: up_db=down_db=1 over 3 ticks -> paddle_y unchanged, moving=0.
- Accel (PADDLE_ACCEL_EN defined): hold down from 0 for 17 ticks -> paddle_y=8*4+8*8+16=112.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong definitions: screen geometry, paddle_y width and the
// paddle direction type used by the paddle, renderer and ball logic.
package pong_pkg;

    localparam int SCREEN_H = 480;
    localparam int Y_W      = 10;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } dir_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-level debounce counter.
// btn_db follows the synchronized level only after it has differed from
// btn_db for DEB_CYCLES consecutive cycles; any return to btn_db restarts
// the count. Raw edge to btn_db change is DEB_CYCLES+2 cycles.
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             db_reg;
    logic             sync_level;

    assign sync_level = sync_reg[1];
    assign btn_db     = db_reg;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], btn_raw};
        end
    end

    // Count cycles of disagreement; accept the new level when the run is long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            db_reg  <= 1'b0;
        end else if (sync_level == db_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            db_reg  <= sync_level;
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle input conditioning and motion: debounces btnU/btnD, derives a
// HOLD/UP/DOWN direction and steps paddle_y once per frame_tick, clamped
// to 0..SCREEN_H-PADDLE_H.
// Optional macro PADDLE_ACCEL_EN: step grows to 2*STEP after 8 consecutive
// ticks in one direction and to 4*STEP after 16.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int DEB_CYCLES = 500000,
    parameter int PADDLE_H   = 80,
    parameter int STEP       = 4,
    parameter int Y_INIT     = 200
) (
    input  logic           ClkPort,
    input  logic           reset,
    input  logic           btnU,
    input  logic           btnD,
    input  logic           frame_tick,
    output logic [Y_W-1:0] paddle_y,
    output logic           up_db,
    output logic           down_db,
    output logic           moving
);

    localparam logic [Y_W:0]   Y_MAX_EXT = (Y_W+1)'(SCREEN_H - PADDLE_H);
    localparam logic [Y_W-1:0] Y_MAX     = Y_W'(SCREEN_H - PADDLE_H);
    localparam logic [Y_W-1:0] Y_RST     = Y_W'(Y_INIT);

    // Index 0 is the up button, index 1 the down button.
    logic [1:0] btn_raw;
    logic [1:0] btn_db;

    assign btn_raw = {btnD, btnU};
    assign up_db   = btn_db[0];
    assign down_db = btn_db[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            btn_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk     (ClkPort),
                .rst     (reset),
                .btn_raw (btn_raw[gi]),
                .btn_db  (btn_db[gi])
            );
        end
    endgenerate

    dir_t state_reg;
    dir_t state_next;

    // Direction register; the position update always uses the previous cycle's decision.
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            state_reg <= HOLD;
        end else begin
            state_reg <= state_next;
        end
    end

    // Direction decision from the debounced levels; conflicting or idle buttons hold.
    always_comb begin
        state_next = HOLD;
        if (up_db && !down_db) begin
            state_next = UP;
        end else if (down_db && !up_db) begin
            state_next = DOWN;
        end
    end

    logic [Y_W:0] step_eff;

`ifdef PADDLE_ACCEL_EN
    logic [2:0] hold_cnt_reg;
    logic [1:0] accel_lvl_reg;
    dir_t       last_dir_reg;
    logic       first_tick;

    // Step size for this tick: a new or reversed direction restarts at STEP.
    always_comb begin
        first_tick = (state_reg != last_dir_reg);
        step_eff   = (Y_W+1)'(STEP);
        if (!first_tick) begin
            case (accel_lvl_reg)
                2'd0:    step_eff = (Y_W+1)'(STEP);
                2'd1:    step_eff = (Y_W+1)'(2 * STEP);
                default: step_eff = (Y_W+1)'(4 * STEP);
            endcase
        end
    end

    // Track consecutive ticks in one direction; every 8 ticks raises the level up to 2.
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            hold_cnt_reg  <= 3'd0;
            accel_lvl_reg <= 2'd0;
            last_dir_reg  <= HOLD;
        end else if (state_reg == HOLD) begin
            hold_cnt_reg  <= 3'd0;
            accel_lvl_reg <= 2'd0;
            last_dir_reg  <= HOLD;
        end else if (frame_tick) begin
            if (first_tick) begin
                hold_cnt_reg  <= 3'd1;
                accel_lvl_reg <= 2'd0;
                last_dir_reg  <= state_reg;
            end else begin
                hold_cnt_reg <= hold_cnt_reg + 3'd1;
                if (hold_cnt_reg == 3'd7 && accel_lvl_reg != 2'd2) begin
                    accel_lvl_reg <= accel_lvl_reg + 2'd1;
                end
            end
        end
    end
`else
    assign step_eff = (Y_W+1)'(STEP);
`endif

    logic [Y_W-1:0] paddle_y_reg;
    logic [Y_W-1:0] paddle_y_next;
    logic           moving_reg;
    logic           moving_next;
    logic [Y_W:0]   y_ext;
    logic [Y_W:0]   y_sum;

    assign paddle_y = paddle_y_reg;
    assign moving   = moving_reg;
    assign y_ext    = {1'b0, paddle_y_reg};
    assign y_sum    = y_ext + step_eff;

    // Clamped position step on frame_tick; moving flags an actual change.
    always_comb begin
        paddle_y_next = paddle_y_reg;
        if (frame_tick) begin
            case (state_reg)
                UP: begin
                    if (y_ext >= step_eff) begin
                        paddle_y_next = paddle_y_reg - step_eff[Y_W-1:0];
                    end else begin
                        paddle_y_next = '0;
                    end
                end
                DOWN: begin
                    if (y_sum <= Y_MAX_EXT) begin
                        paddle_y_next = y_sum[Y_W-1:0];
                    end else begin
                        paddle_y_next = Y_MAX;
                    end
                end
                default: paddle_y_next = paddle_y_reg;
            endcase
        end
        moving_next = frame_tick && (paddle_y_next != paddle_y_reg);
    end

    // Position and motion-flag registers.
    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            paddle_y_reg <= Y_RST;
            moving_reg   <= 1'b0;
        end else begin
            paddle_y_reg <= paddle_y_next;
            moving_reg   <= moving_next;
        end
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Testbench for paddle_ctrl (DEB_CYCLES=4). A spec-level model predicts
// the outputs every cycle; directed literal checks pin key results.
// Optional macro PADDLE_ACCEL_EN enables the acceleration scenario.
module tb_paddle_ctrl;

    localparam int DEB  = 4;
    localparam int STEP = 4;
    localparam int MAXY = 400;

    logic       ClkPort    = 1'b0;
    logic       reset      = 1'b0;
    logic       btnU       = 1'b0;
    logic       btnD       = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] paddle_y;
    logic       up_db;
    logic       down_db;
    logic       moving;

    int n_checks = 0;
    int n_fail   = 0;
    int mv_count = 0;

    paddle_ctrl #(
        .DEB_CYCLES (DEB)
    ) dut (
        .ClkPort    (ClkPort),
        .reset      (reset),
        .btnU       (btnU),
        .btnD       (btnD),
        .frame_tick (frame_tick),
        .paddle_y   (paddle_y),
        .up_db      (up_db),
        .down_db    (down_db),
        .moving     (moving)
    );

    always #5 ClkPort = ~ClkPort;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d (t=%0t)", name, act, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Raw levels reach the debounce stage two edges late; a level is accepted
    // after DEB consecutive disagreeing samples. Direction is decided from
    // the debounced levels one edge before it is used by a tick.
    int m_y      = 200;
    bit m_mov    = 0;
    bit m_up     = 0;
    bit m_dn     = 0;
    int m_run_u  = 0;
    int m_run_d  = 0;
    bit [1:0] m_hist_u = 0;
    bit [1:0] m_hist_d = 0;
    int m_dir    = 0;   // 0 none, 1 up, 2 down
    int m_acc_n  = 0;
    int m_acc_d  = 0;

    always @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            m_y <= 200; m_mov <= 0; m_up <= 0; m_dn <= 0;
            m_run_u <= 0; m_run_d <= 0; m_hist_u <= 0; m_hist_d <= 0;
            m_dir <= 0; m_acc_n <= 0; m_acc_d <= 0;
        end else begin
            int y_new, stp, acc_n, acc_d, ru, rd;
            bit nu, nd;
            y_new = m_y; stp = STEP; acc_n = m_acc_n; acc_d = m_acc_d;
`ifdef PADDLE_ACCEL_EN
            if (m_dir == 0) begin
                acc_n = 0; acc_d = 0;
            end else if (frame_tick) begin
                acc_n = (m_dir != m_acc_d) ? 1 : ((m_acc_n >= 17) ? 17 : m_acc_n + 1);
                acc_d = m_dir;
                stp = (acc_n <= 8) ? STEP : ((acc_n <= 16) ? 2 * STEP : 4 * STEP);
            end
`endif
            if (frame_tick && m_dir == 1) y_new = (m_y - stp < 0) ? 0 : m_y - stp;
            if (frame_tick && m_dir == 2) y_new = (m_y + stp > MAXY) ? MAXY : m_y + stp;
            m_mov   <= frame_tick && (y_new != m_y);
            m_y     <= y_new;
            m_acc_n <= acc_n;
            m_acc_d <= acc_d;
            m_dir   <= (m_up && !m_dn) ? 1 : ((m_dn && !m_up) ? 2 : 0);
            nu = m_up; ru = 0;
            if (m_hist_u[1] != m_up) begin
                ru = m_run_u + 1;
                if (ru == DEB) begin nu = m_hist_u[1]; ru = 0; end
            end
            nd = m_dn; rd = 0;
            if (m_hist_d[1] != m_dn) begin
                rd = m_run_d + 1;
                if (rd == DEB) begin nd = m_hist_d[1]; rd = 0; end
            end
            m_up <= nu; m_run_u <= ru;
            m_dn <= nd; m_run_d <= rd;
            m_hist_u <= {m_hist_u[0], btnU};
            m_hist_d <= {m_hist_d[0], btnD};
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge ClkPort) begin
        if (moving === 1'b1) mv_count++;
        if (paddle_y !== 10'(m_y)) check("cyc_paddle_y", int'(paddle_y), m_y);
        else n_checks++;
        if (up_db !== m_up) check("cyc_up_db", int'(up_db), int'(m_up));
        else n_checks++;
        if (down_db !== m_dn) check("cyc_down_db", int'(down_db), int'(m_dn));
        else n_checks++;
        if (moving !== m_mov) check("cyc_moving", int'(moving), int'(m_mov));
        else n_checks++;
    end

    // ---------------- stimulus ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge ClkPort);
    endtask

    // Back-to-back ticks; returns on the negedge where the last step is visible.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge ClkPort);
        end
        frame_tick = 1'b0;
    endtask

    initial begin
        int mv0;
        #1 reset = 1'b1;
        #1;
        check("rst_paddle_y", int'(paddle_y), 200);
        check("rst_up_db", int'(up_db), 0);
        check("rst_down_db", int'(down_db), 0);
        check("rst_moving", int'(moving), 0);
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(2);

        // Short glitch: 3 cycles high must not be accepted.
        btnU = 1'b1;
        wait_cycles(3);
        btnU = 1'b0;
        wait_cycles(10);
        check("glitch_up_db", int'(up_db), 0);

        // Held press: up_db rises exactly DEB+2 edges after the raw edge.
        btnU = 1'b1;
        wait_cycles(5);
        check("deb_up_db_at5", int'(up_db), 0);
        wait_cycles(1);
        check("deb_up_db_at6", int'(up_db), 1);
        wait_cycles(2);

`ifndef PADDLE_ACCEL_EN
        // Five spaced ticks upward.
        mv0 = mv_count;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            wait_cycles(1);
        end
        check("step_up_y", int'(paddle_y), 180);
        check("step_up_pulses", mv_count - mv0, 5);

        // Both buttons held: no motion.
        btnD = 1'b1;
        wait_cycles(10);
        tick(3);
        check("both_y", int'(paddle_y), 180);
        check("both_moving", int'(moving), 0);
        btnD = 1'b0;
        wait_cycles(10);

        // Up to the top clamp.
        tick(44);
        check("near_top_y", int'(paddle_y), 4);
        tick(1);
        check("top_y", int'(paddle_y), 0);
        check("top_moving", int'(moving), 1);
        tick(1);
        check("top_hold_y", int'(paddle_y), 0);
        check("top_hold_moving", int'(moving), 0);

        // Down to the bottom clamp.
        btnU = 1'b0;
        btnD = 1'b1;
        wait_cycles(10);
        tick(99);
        check("near_max_y", int'(paddle_y), 396);
        tick(1);
        check("max_y", int'(paddle_y), 400);
        check("max_moving", int'(moving), 1);
        tick(2);
        check("max_hold_y", int'(paddle_y), 400);
        check("max_hold_moving", int'(moving), 0);

        // Back up to 120 for the mid-run reset.
        btnD = 1'b0;
        btnU = 1'b1;
        wait_cycles(10);
        tick(70);
        check("pre_reset_y", int'(paddle_y), 120);
`else
        tick(30);
`endif

        // Asynchronous reset between clock edges takes effect immediately.
        #2;
        btnU  = 1'b0;
        btnD  = 1'b0;
        reset = 1'b1;
        #1;
        check("arst_paddle_y", int'(paddle_y), 200);
        check("arst_up_db", int'(up_db), 0);
        check("arst_down_db", int'(down_db), 0);
        check("arst_moving", int'(moving), 0);
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(2);

`ifdef PADDLE_ACCEL_EN
        // Reach the top, idle, then accelerate downward for 17 ticks.
        btnU = 1'b1;
        wait_cycles(10);
        tick(60);
        check("accel_top_y", int'(paddle_y), 0);
        btnU = 1'b0;
        wait_cycles(10);
        btnD = 1'b1;
        wait_cycles(10);
        tick(17);
        check("accel_17_y", int'(paddle_y), 112);
        btnD = 1'b0;
        wait_cycles(10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
